// File: rtl/fixed_chan_sched_if.sv
// Bundles the frame-control, header-table, engine and sample-stream signals of fixed_chan_sched.
// Sample stream: a beat transfers when oSampleValid and iSampleReady are both 1; oSample/oSampleChan hold while oSampleValid=1 and iSampleReady=0.
interface fixed_chan_sched_if;
  logic        iStart;
  logic [3:0]  iNumChannels;
  logic [15:0] iBlockSize;
  logic [2:0]  oCfgChan;
  logic [3:0]  iCfgOrder;
  logic [15:0] iCfgAddr;
  logic        oEngRst;
  logic        oEngEn;
  logic [3:0]  oEngOrder;
  logic [15:0] oEngStartAddr;
  logic        iEngValid;
  logic [15:0] iEngSample;
  logic [15:0] oSample;
  logic [2:0]  oSampleChan;
  logic        oSampleValid;
  logic        iSampleReady;
  logic        oBusy;
  logic        oFrameDone;
  logic        oError;
  logic [2:0]  oDbgState;

  modport slave (
    input  iStart, iNumChannels, iBlockSize, iCfgOrder, iCfgAddr,
           iEngValid, iEngSample, iSampleReady,
    output oCfgChan, oEngRst, oEngEn, oEngOrder, oEngStartAddr,
           oSample, oSampleChan, oSampleValid, oBusy, oFrameDone, oError, oDbgState
  );

  modport master (
    output iStart, iNumChannels, iBlockSize, iCfgOrder, iCfgAddr,
           iEngValid, iEngSample, iSampleReady,
    input  oCfgChan, oEngRst, oEngEn, oEngOrder, oEngStartAddr,
           oSample, oSampleChan, oSampleValid, oBusy, oFrameDone, oError, oDbgState
  );
endinterface

// File: rtl/fixed_chan_sched.sv
// Per-channel sequencer for the fixed-predictor decode engine with a 2-entry output skid FIFO.
// SCHED_WDOG_EN adds a stall watchdog (WDOG_CYCLES) that abandons the frame if the engine goes quiet.
module fixed_chan_sched #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CH     = 8
`ifdef SCHED_WDOG_EN
  ,
  parameter int WDOG_CYCLES = 64
`endif
) (
  input logic               iClk,
  input logic               iRst_n,
  fixed_chan_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD1, S_LOAD2, S_ENGRST, S_RUN, S_NEXT, S_DONE
  } state_t;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  state_t          state_q, state_d;
  logic [2:0]      chan_q, chan_d;
  logic [3:0]      num_q, num_d;
  logic [15:0]     blk_q, blk_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic            eng_rst_q, eng_rst_d;
  logic            eng_en_q, eng_en_d;
  logic [3:0]      eng_order_q, eng_order_d;
  logic [15:0]     eng_addr_q, eng_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0][18:0] mem_q, mem_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      fcnt_q, fcnt_d;
`ifdef SCHED_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
  logic [WDW-1:0]  wdog_q, wdog_d;
`endif

  logic pop, push_req, push_ok, overflow, en_next;

  assign pop      = (fcnt_q != 2'd0) && bus.iSampleReady;
  assign push_req = (state_q == S_RUN) && bus.iEngValid;
  assign push_ok  = push_req && ((fcnt_q != 2'd2) || pop);
  assign overflow = push_req && !push_ok;
  // Enable is registered, so it looks one pop ahead to keep the engine running at full rate.
  assign en_next  = (fcnt_q == 2'd0) || ((fcnt_q == 2'd1) && pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fcnt_d   = fcnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {chan_q, bus.iEngSample};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    num_d       = num_q;
    blk_d       = blk_q;
    cnt_d       = cnt_q;
    rst_cnt_d   = rst_cnt_q;
    eng_rst_d   = eng_rst_q;
    eng_en_d    = eng_en_q;
    eng_order_d = eng_order_q;
    eng_addr_d  = eng_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef SCHED_WDOG_EN
    wdog_d      = wdog_q;
`endif
    if (overflow) err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          num_d  = bus.iNumChannels;
          blk_d  = bus.iBlockSize;
          chan_d = 3'd0;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if ((bus.iNumChannels == 4'd0) || (bus.iNumChannels > 4'(MAX_CH)) ||
              (bus.iBlockSize == 16'd0)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD1;
          end
        end
      end
      S_LOAD1: state_d = S_LOAD2;
      S_LOAD2: begin
        eng_order_d = bus.iCfgOrder;
        eng_addr_d  = bus.iCfgAddr;
        if (bus.iCfgOrder > 4'd4) begin
          err_d   = 1'b1;
          state_d = S_NEXT;
        end else begin
          eng_rst_d = 1'b1;
          rst_cnt_d = '0;
          state_d   = S_ENGRST;
        end
      end
      S_ENGRST: begin
        if (rst_cnt_q == RST_LAST) begin
          eng_rst_d = 1'b0;
          eng_en_d  = en_next;
          cnt_d     = 16'd0;
`ifdef SCHED_WDOG_EN
          wdog_d    = '0;
`endif
          state_d   = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        eng_en_d = en_next;
        if (push_req) begin
          cnt_d = cnt_q + 16'd1;
`ifdef SCHED_WDOG_EN
          wdog_d = '0;
`endif
          if (cnt_q + 16'd1 == blk_q) begin
            eng_en_d = 1'b0;
            state_d  = S_NEXT;
          end
        end
`ifdef SCHED_WDOG_EN
        else if (eng_en_q) begin
          if (wdog_q == WDOG_LAST) begin
            err_d    = 1'b1;
            eng_en_d = 1'b0;
            state_d  = S_DONE;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
`endif
      end
      S_NEXT: begin
        if ({1'b0, chan_q} == num_q - 4'd1) begin
          state_d = S_DONE;
        end else begin
          chan_d  = chan_q + 3'd1;
          state_d = S_LOAD1;
        end
      end
      S_DONE: begin
        // The done pulse is held back until the last sample has been consumed.
        if (fcnt_q == 2'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= S_IDLE;
      chan_q      <= 3'd0;
      num_q       <= 4'd0;
      blk_q       <= 16'd0;
      cnt_q       <= 16'd0;
      rst_cnt_q   <= '0;
      eng_rst_q   <= 1'b0;
      eng_en_q    <= 1'b0;
      eng_order_q <= 4'd0;
      eng_addr_q  <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_q       <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      fcnt_q      <= 2'd0;
`ifdef SCHED_WDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      num_q       <= num_d;
      blk_q       <= blk_d;
      cnt_q       <= cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      eng_rst_q   <= eng_rst_d;
      eng_en_q    <= eng_en_d;
      eng_order_q <= eng_order_d;
      eng_addr_q  <= eng_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fcnt_q      <= fcnt_d;
`ifdef SCHED_WDOG_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign bus.oCfgChan      = chan_q;
  assign bus.oEngRst       = eng_rst_q;
  assign bus.oEngEn        = eng_en_q;
  assign bus.oEngOrder     = eng_order_q;
  assign bus.oEngStartAddr = eng_addr_q;
  assign bus.oSample       = mem_q[rd_ptr_q][15:0];
  assign bus.oSampleChan   = mem_q[rd_ptr_q][18:16];
  assign bus.oSampleValid  = (fcnt_q != 2'd0);
  assign bus.oBusy         = busy_q;
  assign bus.oFrameDone    = done_q;
  assign bus.oError        = err_q;
  assign bus.oDbgState     = state_q;

endmodule

// File: tb/tb_fixed_chan_sched.sv
// Directed + randomized bench for fixed_chan_sched: a frame-level model predicts the sample stream,
// engine-visible channel sequence and error flag from the header table and frame parameters.
module tb_fixed_chan_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fixed_chan_sched_if bus();

  fixed_chan_sched dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [18:0] exp_q[$];
  int          eng_ch_q[$];
  logic [15:0] smp[8][32];
  logic [3:0]  cfg_order[8];
  logic [15:0] cfg_addr[8];

  int cur_blk = 0;
  int eng_limit = 1000;
  int ready_mode = 0;
  int done_cnt = 0;
  bit en_seen = 0;
  int cycle = 0;
  int eng_ch = 0;
  int eng_k = 0;
  int eng_cyc = 0;
  int last_valid_cyc = 0;
  int done_gap = 0;
  bit prev_rst = 0;

  assign bus.iCfgOrder = cfg_order[bus.oCfgChan];
  assign bus.iCfgAddr  = cfg_addr[bus.oCfgChan];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer: drives ready, then scores any beat that will transfer at the next edge.
  initial begin
    bus.iSampleReady = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      case (ready_mode)
        0:       bus.iSampleReady = 1'b1;
        1:       bus.iSampleReady = ((cycle % 4) == 3);
        default: bus.iSampleReady = 1'($urandom_range(0, 1));
      endcase
      if (rst_n) begin
        if (bus.oEngEn) en_seen = 1'b1;
        if (bus.oFrameDone) done_cnt++;
        if (bus.oSampleValid && bus.iSampleReady) begin
          if (exp_q.size() == 0) chk("sample_expected", {13'd0, bus.oSampleChan, bus.oSample}, 32'h7_FFFF);
          else chk("sample", {13'd0, bus.oSampleChan, bus.oSample}, {13'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Engine: picks up the channel at each reset pulse and emits that channel's samples while enabled.
  initial begin
    bus.iEngValid  = 1'b0;
    bus.iEngSample = 16'd0;
    forever begin
      @(negedge clk);
      eng_cyc++;
      bus.iEngValid = 1'b0;
      if (!rst_n) begin
        prev_rst = 1'b0;
        eng_k    = 0;
      end else begin
        if (bus.oFrameDone) done_gap = eng_cyc - last_valid_cyc - 1;
        if (bus.oEngRst && !prev_rst) begin
          chk("eng_run_expected", 32'(eng_ch_q.size() != 0), 1);
          if (eng_ch_q.size() != 0) begin
            eng_ch = eng_ch_q.pop_front();
            chk("eng_start_addr", {16'd0, bus.oEngStartAddr}, {16'd0, cfg_addr[eng_ch]});
            chk("eng_order", {28'd0, bus.oEngOrder}, {28'd0, cfg_order[eng_ch]});
          end
          eng_k = 0;
        end
        prev_rst = bus.oEngRst;
        if (bus.oEngEn && eng_k < cur_blk && eng_k < eng_limit && $urandom_range(0, 3) != 0) begin
          bus.iEngValid  = 1'b1;
          bus.iEngSample = smp[eng_ch][eng_k];
          eng_k++;
          last_valid_cyc = eng_cyc;
        end
      end
    end
  end

  // Reference: channels run in ascending order, bad-order channels are skipped and flag an error.
  task automatic build_model(input int n, input int blk, output bit exp_err, output bit cfg_bad);
    exp_q.delete();
    eng_ch_q.delete();
    cur_blk = blk;
    eng_ch  = 0;
    exp_err = 1'b0;
    cfg_bad = (n < 1) || (n > 8) || (blk < 1);
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 32; k++) smp[c][k] = 16'($urandom);
    if (cfg_bad) begin
      exp_err = 1'b1;
    end else begin
      for (int c = 0; c < n; c++) begin
        if (cfg_order[c] > 4) exp_err = 1'b1;
        else begin
          eng_ch_q.push_back(c);
          for (int k = 0; k < blk; k++) exp_q.push_back({3'(c), smp[c][k]});
        end
      end
    end
  endtask

  task automatic start_frame(input int n, input int blk);
    @(negedge clk);
    bus.iNumChannels = 4'(n);
    bus.iBlockSize   = 16'(blk);
    bus.iStart       = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (bus.oFrameDone !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("frame_done_seen", {31'd0, bus.oFrameDone}, 1);
  endtask

  task automatic run_frame(input int n, input int blk, input int budget, output int cyc);
    bit exp_err, cfg_bad;
    int base;
    build_model(n, blk, exp_err, cfg_bad);
    base = done_cnt;
    start_frame(n, blk);
    chk("error_after_start", {31'd0, bus.oError}, {31'd0, cfg_bad});
    wait_done(budget, cyc);
    chk("frame_error", {31'd0, bus.oError}, {31'd0, exp_err});
    chk("busy_after_done", {31'd0, bus.oBusy}, 0);
    chk("samples_left", exp_q.size(), 0);
    chk("channels_not_run", eng_ch_q.size(), 0);
    @(negedge clk);
    chk("done_pulse_width", {31'd0, bus.oFrameDone}, 0);
    chk("done_count", done_cnt - base, 1);
  endtask

  initial begin
    #3ms;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int t;
    bit exp_err, cfg_bad;
    bus.iStart       = 1'b0;
    bus.iNumChannels = 4'd0;
    bus.iBlockSize   = 16'd0;
    for (int c = 0; c < 8; c++) begin
      cfg_order[c] = 4'(c % 5);
      cfg_addr[c]  = 16'(c * 16'h0100);
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.oBusy}, 0);
    chk("rst_sample_valid", {31'd0, bus.oSampleValid}, 0);
    chk("rst_eng_en_rst", {30'd0, bus.oEngEn, bus.oEngRst}, 0);
    chk("rst_done_err", {30'd0, bus.oFrameDone, bus.oError}, 0);
    chk("rst_cfg_chan", {29'd0, bus.oCfgChan}, 0);
    chk("rst_sample", {13'd0, bus.oSampleChan, bus.oSample}, 0);
    rst_n = 1'b1;

    // Stereo, free-flowing output
    cfg_order[0] = 4'd2; cfg_order[1] = 4'd4;
    cfg_addr[0]  = 16'h0004; cfg_addr[1] = 16'h0040;
    ready_mode = 0;
    run_frame(2, 16, 2000, cyc);

    // Backpressure: ready 3 low / 1 high
    ready_mode = 1;
    run_frame(2, 16, 4000, cyc);

    // Bad order on the middle channel
    ready_mode = 0;
    cfg_order[2] = 4'd3; cfg_addr[2] = 16'h0123; cfg_order[1] = 4'd7;
    run_frame(3, 10, 2000, cyc);
    cfg_order[1] = 4'd4;

    // Zero block size, then a valid frame clears the error
    en_seen = 1'b0;
    run_frame(1, 0, 20, cyc);
    chk("zero_blk_latency_le3", 32'(cyc <= 3), 1);
    chk("zero_blk_no_enable", {31'd0, en_seen}, 0);
    run_frame(1, 4, 500, cyc);

    // Channel count out of range at both ends
    run_frame(0, 8, 20, cyc);
    run_frame(9, 8, 20, cyc);
    run_frame(8, 1, 2000, cyc);

    // Randomized frames
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 8; c++) begin
        cfg_order[c] = 4'($urandom_range(0, 5));
        cfg_addr[c]  = 16'((c << 12) | $urandom_range(0, 16'h0FFF));
      end
      run_frame($urandom_range(1, 8), $urandom_range(1, 24), 6000, cyc);
    end

    // Reset while channel 1 is running
    ready_mode = 0;
    for (int c = 0; c < 8; c++) cfg_order[c] = 4'd1;
    build_model(2, 16, exp_err, cfg_bad);
    start_frame(2, 16);
    t = 0;
    while (!(eng_ch == 1 && bus.oEngEn) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("reached_chan1_run", {31'd0, bus.oEngEn}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, bus.oBusy}, 0);
    chk("async_rst_eng_en", {31'd0, bus.oEngEn}, 0);
    chk("async_rst_fifo_empty", {31'd0, bus.oSampleValid}, 0);
    chk("async_rst_cfg_chan", {29'd0, bus.oCfgChan}, 0);
    chk("async_rst_eng_addr", {16'd0, bus.oEngStartAddr}, 0);
    exp_q.delete();
    eng_ch_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1, 8, 1000, cyc);

    // Engine stalls after 5 samples
    eng_limit = 5;
    build_model(2, 16, exp_err, cfg_bad);
`ifdef SCHED_WDOG_EN
    start_frame(2, 16);
    wait_done(400, cyc);
    chk("wdog_error", {31'd0, bus.oError}, 1);
    chk("wdog_gap_64_66", 32'(done_gap >= 64 && done_gap <= 66), 1);
    chk("wdog_partial_out", exp_q.size(), 32 - 5);
`else
    start_frame(2, 16);
    repeat (150) @(negedge clk);
    chk("stall_busy_held", {31'd0, bus.oBusy}, 1);
    chk("stall_no_error", {31'd0, bus.oError}, 0);
    chk("stall_partial_out", exp_q.size(), 32 - 5);
`endif
    rst_n = 1'b0;
    exp_q.delete();
    eng_ch_q.delete();
    eng_limit = 1000;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(2, 6, 1000, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
